spi_pingpong_ctrl: RTL and testbench
====================================

SPI_PINGPONG_CTRL -- requirements
Module: spi_pingpong_ctrl

Interface
REQ-001 SHALL have parameter BUF_SIZE, default 6, meaning words per bank buffer.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, meaning pointer width; BUF_SIZE <= 2**ADDR_WIDTH - 1.
REQ-003 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- signal_cycle  in  1  NITTA computational-cycle boundary pulse.
- nitta_wr  in  1  NITTA word write into its bank.
- nitta_oe  in  1  NITTA word read from its bank.
- cs  in  1  SPI chip select, active-low, synchronous to clk.
- spi_word_done  in  1  one-cycle pulse per completed SPI word.
- err_clr  in  1  clears sticky error flags.
- bank_sel  out  1  bank owned by NITTA; SPI owns !bank_sel.
- nitta_wr_addr  out  ADDR_WIDTH  NITTA write pointer.
- nitta_rd_addr  out  ADDR_WIDTH  NITTA read pointer.
- spi_addr  out  ADDR_WIDTH  SPI-side word pointer.
- buf_clear  out  2  per-bank clear, bit i clears bank i.
- flag_start  out  1  one-cycle pulse, SPI transaction began.
- flag_stop  out  1  one-cycle pulse, SPI transaction ended.
- pending_swap  out  1  swap deferred until transaction end.
- err_nitta  out  1  sticky: NITTA access beyond BUF_SIZE.
- err_spi  out  1  sticky: SPI word beyond BUF_SIZE.
- err_cycle  out  1  sticky: signal_cycle lost while swap pending.

Function
REQ-004 SHALL implement FSM states IDLE, XFER, SWAP; all outputs registered.
REQ-005 IDLE -> XFER when cs=0; flag_start=1 for the following cycle only.
REQ-006 XFER -> SWAP when cs=1 and pending_swap=1; XFER -> IDLE when cs=1 and pending_swap=0; either exit pulses flag_stop for one cycle.
REQ-007 SWAP SHALL last one cycle, then go to IDLE, or to XFER (with flag_start) if cs=0.
REQ-008 signal_cycle in IDLE SHALL swap on the next edge: bank_sel toggles, all three pointers go to 0, buf_clear bit of the new NITTA bank pulses for one cycle.
REQ-009 signal_cycle in XFER SHALL set pending_swap; the swap executes in SWAP, which clears pending_swap.
REQ-010 signal_cycle while pending_swap=1 SHALL set err_cycle; only one swap results.
REQ-011 signal_cycle and cs=0 in the same IDLE cycle SHALL perform the swap and enter XFER together; spi_addr=0 on the new SPI bank.
REQ-012 nitta_wr SHALL increment nitta_wr_addr; at value BUF_SIZE the pointer holds and err_nitta is set.
REQ-013 nitta_oe SHALL increment nitta_rd_addr with the same saturation and err_nitta rule.
REQ-014 spi_word_done SHALL increment spi_addr only in XFER; at BUF_SIZE it holds and err_spi is set; ignored in IDLE and SWAP.
REQ-015 nitta_wr or nitta_oe coincident with a swap SHALL act on the old bank at the current pointer; the pointer then resets to 0 and the access is not counted in the new bank.
REQ-016 err_clr SHALL clear all err_* flags; a simultaneous error set SHALL win.
REQ-017 spi_addr SHALL reset to 0 on every XFER entry.

Reset
REQ-018 While rst=1: state IDLE, bank_sel=0, all pointers=0, buf_clear=2'b11, flag_start/flag_stop/pending_swap/err_*=0.
REQ-019 buf_clear SHALL return to 2'b00 on the first clk edge after rst deasserts.
REQ-020 rst asserted mid-XFER SHALL abort the transaction immediately without a flag_stop pulse.

Verification
REQ-021 Reset, then signal_cycle in IDLE -> next cycle bank_sel=1, buf_clear=2'b10 for one cycle, pointers=0.
REQ-022 cs=0, three spi_word_done pulses, signal_cycle mid-transfer, cs=1 -> spi_addr=3, pending_swap=1, flag_stop pulse, bank_sel toggles one cycle later, pending_swap=0.
REQ-023 Seven nitta_wr with BUF_SIZE=6 -> nitta_wr_addr=6, err_nitta=1; err_clr -> err_nitta=0.
REQ-024 Two signal_cycle pulses during one XFER -> err_cycle=1, exactly one bank_sel toggle after cs rises.
REQ-025 signal_cycle and cs=0 in the same cycle from IDLE -> bank_sel toggles, flag_start pulses, state XFER, spi_addr=0.
REQ-026 rst asserted during XFER with spi_addr=2 -> all outputs at reset values asynchronously, no flag_stop pulse.

Source files
------------

// File: rtl/spi_pingpong_ctrl.sv
// Ping-pong bank controller between the NITTA core and an SPI slave.
// NITTA owns bank_sel, SPI owns the other bank; swaps wait for SPI idle.
module spi_pingpong_ctrl #(
    parameter int BUF_SIZE   = 6,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signal_cycle,
    input  logic                  nitta_wr,
    input  logic                  nitta_oe,
    input  logic                  cs,
    input  logic                  spi_word_done,
    input  logic                  err_clr,
    output logic                  bank_sel,
    output logic [ADDR_WIDTH-1:0] nitta_wr_addr,
    output logic [ADDR_WIDTH-1:0] nitta_rd_addr,
    output logic [ADDR_WIDTH-1:0] spi_addr,
    output logic [1:0]            buf_clear,
    output logic                  flag_start,
    output logic                  flag_stop,
    output logic                  pending_swap,
    output logic                  err_nitta,
    output logic                  err_spi,
    output logic                  err_cycle
);

    typedef enum logic [1:0] {IDLE, XFER, SWAP} state_t;

    localparam logic [ADDR_WIDTH-1:0] PTR_MAX = ADDR_WIDTH'(BUF_SIZE);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    state_t state_q, state_d;

    logic                  bank_sel_q, bank_sel_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH-1:0] spi_addr_q, spi_addr_d;
    logic [1:0]            buf_clear_q, buf_clear_d;
    logic                  flag_start_q, flag_start_d;
    logic                  flag_stop_q, flag_stop_d;
    logic                  pending_q, pending_d;
    logic                  err_nitta_q, err_nitta_d;
    logic                  err_spi_q, err_spi_d;
    logic                  err_cycle_q, err_cycle_d;

    logic swap;
    logic enter_xfer;
    logic wr_full;
    logic rd_full;
    logic spi_full;
    logic spi_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A cycle boundary coinciding with cs rising still has to swap.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (!cs) state_d = XFER;
            XFER: begin
                if (cs) begin
                    state_d = (pending_q || signal_cycle) ? SWAP : IDLE;
                end
            end
            SWAP: state_d = cs ? IDLE : XFER;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        swap       = ((state_q == IDLE) && signal_cycle) || (state_q == SWAP);
        enter_xfer = (state_q != XFER) && (state_d == XFER);

        bank_sel_d  = bank_sel_q ^ swap;
        buf_clear_d = 2'b00;
        if (swap) begin
            buf_clear_d = bank_sel_d ? 2'b10 : 2'b01;
        end

        flag_start_d = enter_xfer;
        flag_stop_d  = (state_q == XFER) && cs;

        pending_d = pending_q;
        if (state_q == SWAP) begin
            pending_d = 1'b0;
        end else if ((state_q == XFER) && signal_cycle) begin
            pending_d = 1'b1;
        end

        // Accesses on a swap edge land in the old bank; pointer restarts.
        wr_full   = nitta_wr && (wr_addr_q == PTR_MAX);
        wr_addr_d = wr_addr_q;
        if (swap) begin
            wr_addr_d = '0;
        end else if (nitta_wr && !wr_full) begin
            wr_addr_d = wr_addr_q + PTR_ONE;
        end

        rd_full   = nitta_oe && (rd_addr_q == PTR_MAX);
        rd_addr_d = rd_addr_q;
        if (swap) begin
            rd_addr_d = '0;
        end else if (nitta_oe && !rd_full) begin
            rd_addr_d = rd_addr_q + PTR_ONE;
        end

        spi_inc    = (state_q == XFER) && spi_word_done;
        spi_full   = spi_inc && (spi_addr_q == PTR_MAX);
        spi_addr_d = spi_addr_q;
        if (swap || enter_xfer) begin
            spi_addr_d = '0;
        end else if (spi_inc && !spi_full) begin
            spi_addr_d = spi_addr_q + PTR_ONE;
        end

        err_nitta_d = wr_full || rd_full || (err_nitta_q && !err_clr);
        err_spi_d   = spi_full || (err_spi_q && !err_clr);
        err_cycle_d = (signal_cycle && pending_q) || (err_cycle_q && !err_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_sel_q   <= 1'b0;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            spi_addr_q   <= '0;
            buf_clear_q  <= 2'b11;
            flag_start_q <= 1'b0;
            flag_stop_q  <= 1'b0;
            pending_q    <= 1'b0;
            err_nitta_q  <= 1'b0;
            err_spi_q    <= 1'b0;
            err_cycle_q  <= 1'b0;
        end else begin
            bank_sel_q   <= bank_sel_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            spi_addr_q   <= spi_addr_d;
            buf_clear_q  <= buf_clear_d;
            flag_start_q <= flag_start_d;
            flag_stop_q  <= flag_stop_d;
            pending_q    <= pending_d;
            err_nitta_q  <= err_nitta_d;
            err_spi_q    <= err_spi_d;
            err_cycle_q  <= err_cycle_d;
        end
    end

    assign bank_sel      = bank_sel_q;
    assign nitta_wr_addr = wr_addr_q;
    assign nitta_rd_addr = rd_addr_q;
    assign spi_addr      = spi_addr_q;
    assign buf_clear     = buf_clear_q;
    assign flag_start    = flag_start_q;
    assign flag_stop     = flag_stop_q;
    assign pending_swap  = pending_q;
    assign err_nitta     = err_nitta_q;
    assign err_spi       = err_spi_q;
    assign err_cycle     = err_cycle_q;

endmodule

// File: tb/tb_spi_pingpong_ctrl.sv
// Directed bench for spi_pingpong_ctrl; expected output snapshots are
// queued as stimulus is driven and popped after each clock edge.
module tb_spi_pingpong_ctrl;

    localparam int BS = 6;
    localparam int AW = 3;

    logic          clk;
    logic          rst;
    logic          signal_cycle;
    logic          nitta_wr;
    logic          nitta_oe;
    logic          cs;
    logic          spi_word_done;
    logic          err_clr;
    logic          bank_sel;
    logic [AW-1:0] nitta_wr_addr;
    logic [AW-1:0] nitta_rd_addr;
    logic [AW-1:0] spi_addr;
    logic [1:0]    buf_clear;
    logic          flag_start;
    logic          flag_stop;
    logic          pending_swap;
    logic          err_nitta;
    logic          err_spi;
    logic          err_cycle;

    typedef struct {
        logic          bank;
        logic [AW-1:0] wr;
        logic [AW-1:0] rd;
        logic [AW-1:0] spi;
        logic [1:0]    clr;
        logic          fs;
        logic          fp;
        logic          pend;
        logic          en;
        logic          es;
        logic          ec;
    } exp_t;

    exp_t e;
    exp_t sb[$];
    int   total;
    int   passed;

    spi_pingpong_ctrl #(.BUF_SIZE(BS), .ADDR_WIDTH(AW)) dut (
        .clk(clk),
        .rst(rst),
        .signal_cycle(signal_cycle),
        .nitta_wr(nitta_wr),
        .nitta_oe(nitta_oe),
        .cs(cs),
        .spi_word_done(spi_word_done),
        .err_clr(err_clr),
        .bank_sel(bank_sel),
        .nitta_wr_addr(nitta_wr_addr),
        .nitta_rd_addr(nitta_rd_addr),
        .spi_addr(spi_addr),
        .buf_clear(buf_clear),
        .flag_start(flag_start),
        .flag_stop(flag_stop),
        .pending_swap(pending_swap),
        .err_nitta(err_nitta),
        .err_spi(err_spi),
        .err_cycle(err_cycle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input string fld,
                       input logic [7:0] obs, input logic [7:0] want);
        total++;
        assert (obs === want) begin
            passed++;
        end else begin
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, obs, want);
        end
    endtask

    task automatic cmp(input string tag);
        exp_t x;
        if (sb.size() == 0) begin
            total++;
            $error("FAIL %s scoreboard empty", tag);
            return;
        end
        x = sb.pop_front();
        chk(tag, "bank_sel",   8'(bank_sel),      8'(x.bank));
        chk(tag, "wr_addr",    8'(nitta_wr_addr), 8'(x.wr));
        chk(tag, "rd_addr",    8'(nitta_rd_addr), 8'(x.rd));
        chk(tag, "spi_addr",   8'(spi_addr),      8'(x.spi));
        chk(tag, "buf_clear",  8'(buf_clear),     8'(x.clr));
        chk(tag, "flag_start", 8'(flag_start),    8'(x.fs));
        chk(tag, "flag_stop",  8'(flag_stop),     8'(x.fp));
        chk(tag, "pending",    8'(pending_swap),  8'(x.pend));
        chk(tag, "err_nitta",  8'(err_nitta),     8'(x.en));
        chk(tag, "err_spi",    8'(err_spi),       8'(x.es));
        chk(tag, "err_cycle",  8'(err_cycle),     8'(x.ec));
    endtask

    task automatic push();
        sb.push_back(e);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        cmp(tag);
    endtask

    task automatic reset_exp();
        e.bank = 1'b0;
        e.wr   = '0;
        e.rd   = '0;
        e.spi  = '0;
        e.clr  = 2'b11;
        e.fs   = 1'b0;
        e.fp   = 1'b0;
        e.pend = 1'b0;
        e.en   = 1'b0;
        e.es   = 1'b0;
        e.ec   = 1'b0;
    endtask

    initial begin
        total         = 0;
        passed        = 0;
        rst           = 1'b1;
        signal_cycle  = 1'b0;
        nitta_wr      = 1'b0;
        nitta_oe      = 1'b0;
        cs            = 1'b1;
        spi_word_done = 1'b0;
        err_clr       = 1'b0;

        reset_exp();
        #12;
        push();
        cmp("reset");

        rst = 1'b0;
        e.clr = 2'b00;
        push();
        tick("rst_release");

        // Swap from IDLE
        signal_cycle = 1'b1;
        e.bank = 1'b1;
        e.clr  = 2'b10;
        push();
        tick("idle_swap");
        signal_cycle = 1'b0;
        e.clr = 2'b00;
        push();
        tick("swap_done");

        // Write pointer saturation and error clear
        nitta_wr = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            e.wr = (i > BS) ? AW'(BS) : AW'(i);
            e.en = (i == 7);
            push();
            tick("wr_sat");
        end
        nitta_wr = 1'b0;
        err_clr = 1'b1;
        e.en = 1'b0;
        push();
        tick("err_clr");
        err_clr = 1'b0;

        nitta_oe = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            e.rd = AW'(i);
            push();
            tick("rd_inc");
        end
        nitta_oe = 1'b0;

        // Transfer with deferred swap
        cs = 1'b0;
        e.fs = 1'b1;
        push();
        tick("xfer_start");
        spi_word_done = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            e.fs  = 1'b0;
            e.spi = AW'(i);
            push();
            tick("spi_word");
        end
        spi_word_done = 1'b0;
        signal_cycle = 1'b1;
        e.pend = 1'b1;
        push();
        tick("pend_set");
        signal_cycle = 1'b0;
        cs = 1'b1;
        e.fp = 1'b1;
        push();
        tick("flag_stop");
        e.fp   = 1'b0;
        e.bank = 1'b0;
        e.pend = 1'b0;
        e.wr   = '0;
        e.rd   = '0;
        e.spi  = '0;
        e.clr  = 2'b01;
        push();
        tick("pend_swap");
        spi_word_done = 1'b1;
        e.clr = 2'b00;
        push();
        tick("idle_word_ignored");
        spi_word_done = 1'b0;

        // Double cycle pulse in one transfer, SPI overflow
        cs = 1'b0;
        e.fs = 1'b1;
        push();
        tick("xfer2_start");
        signal_cycle = 1'b1;
        nitta_wr = 1'b1;
        e.fs   = 1'b0;
        e.pend = 1'b1;
        e.wr   = AW'(1);
        push();
        tick("sc1");
        nitta_wr = 1'b0;
        e.ec = 1'b1;
        push();
        tick("sc2");
        signal_cycle = 1'b0;
        spi_word_done = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            e.spi = (i > BS) ? AW'(BS) : AW'(i);
            e.es  = (i == 7);
            push();
            tick("spi_sat");
        end
        spi_word_done = 1'b0;
        cs = 1'b1;
        nitta_wr = 1'b1;
        e.fp = 1'b1;
        e.wr = AW'(2);
        push();
        tick("stop2");
        e.fp   = 1'b0;
        e.bank = 1'b1;
        e.clr  = 2'b10;
        e.pend = 1'b0;
        e.wr   = '0;
        e.spi  = '0;
        push();
        tick("swap_with_wr");
        nitta_wr = 1'b0;
        e.clr = 2'b00;
        push();
        tick("one_toggle");

        // Error set beats simultaneous clear
        nitta_oe = 1'b1;
        for (int i = 1; i <= BS; i++) begin
            e.rd = AW'(i);
            push();
            tick("rd_fill");
        end
        err_clr = 1'b1;
        e.en = 1'b1;
        e.es = 1'b0;
        e.ec = 1'b0;
        push();
        tick("clr_vs_set");
        nitta_oe = 1'b0;
        err_clr = 1'b0;

        // Cycle pulse and cs fall together in IDLE
        signal_cycle = 1'b1;
        cs = 1'b0;
        e.bank = 1'b0;
        e.clr  = 2'b01;
        e.fs   = 1'b1;
        e.rd   = '0;
        push();
        tick("sc_cs_same");
        signal_cycle = 1'b0;
        spi_word_done = 1'b1;
        e.fs  = 1'b0;
        e.clr = 2'b00;
        e.spi = AW'(1);
        push();
        tick("xfer3_word1");
        e.spi = AW'(2);
        push();
        tick("xfer3_word2");
        spi_word_done = 1'b0;

        // Asynchronous reset mid-transfer
        #2;
        rst = 1'b1;
        #1;
        reset_exp();
        push();
        cmp("async_rst");
        cs = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        e.clr = 2'b00;
        push();
        tick("post_rst");
        push();
        tick("no_stop");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
